demux_1x4_tdm: RTL
==================

# demux_1x4_tdm

Registered 1-to-4 time-division demultiplexer: the receive-side counterpart of the team's 4:1 mux. It takes a single serial lane carrying slots 0..3 in rotation and distributes each slot to its own output channel. A complete four-slot frame is presented on all four outputs simultaneously, with a one-cycle frame strobe. It sits after any 4:1 time-multiplexed link and restores the original i0..i3 channel values.

## Interface
- WIDTH, 1, data width of the serial lane and of each output channel.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  serial slot data; sampled only when din_valid=1.
- din_valid  input  1  din carries a slot this cycle.
- sync  input  1  frame alignment; forces the current slot to 0.
- y0, y1, y2, y3  output  WIDTH each  demultiplexed channels; hold the last complete frame.
- S1, S0  output  1 each  current slot pointer, the slot the next valid din is written to.
- frame_valid  output  1  one-cycle pulse when y0..y3 update.

## Operation
- State: 2-bit slot counter {S1,S0}; shadow registers sh0, sh1, sh2 (WIDTH each); output registers y0..y3.
- Effective slot each cycle is 0 if sync=1, otherwise {S1,S0}.
- din_valid=1, effective slot k<3: shadow register sh_k <= din; counter <= k+1; outputs unchanged.
- din_valid=1, effective slot 3: y0<=sh0, y1<=sh1, y2<=sh2, y3<=din, all on the same edge; frame_valid<=1; counter wraps to 0.
- din_valid=0, sync=0: no state change; the counter holds, so gaps between slots are allowed.
- din_valid=0, sync=1: counter <= 0 and the partial frame is discarded. Shadow contents are stale but are always rewritten before the next frame completes.
- sync=1 together with din_valid=1: din is written to slot 0 (sh0) and counter <= 1. Any partial frame is discarded.
- Outputs y0..y3 change only on frame completion. A partial frame never reaches the outputs.
- frame_valid is 0 on every cycle other than the one following a slot-3 capture.

## Timing
- Reset (asynchronous, rst_n=0): S1=S0=0, y0..y3=0, sh0..sh2=0, frame_valid=0. With DEMUX_FRAME_CNT_EN defined, frame_cnt=0.
- Reset released mid-frame: the block restarts at slot 0 and no output is updated.
- Latency: y0..y3 and frame_valid become visible one cycle after the clock edge that samples slot 3.
- Minimum frame time: 4 cycles. Back-to-back frames give frame_valid high on every 4th cycle.
- S1/S0 are registered and always reflect the slot for the next valid sample.

## Configuration
- Macro DEMUX_FRAME_CNT_EN.
- Defined: adds output frame_cnt (8 bits), which increments on every frame completion, together with frame_valid, and wraps 255->0.
- frame_cnt is reset to 0 by rst_n. sync alone does not change it.
- Not defined: frame_cnt does not exist and the rest of the behaviour is unchanged.

## Test plan
- Reset: rst_n=0 with random inputs -> y0..y3=0, S1=S0=0, frame_valid=0. Release rst_n; with no valid inputs, outputs stay 0.
- Basic frame, WIDTH=1: din 0,1,0,1 on 4 consecutive valid cycles -> next cycle y0=0, y1=1, y2=0, y3=1 and frame_valid=1 for exactly 1 cycle. Outputs then hold.
- Gapped input: same frame with din_valid low for 3 cycles between slots 1 and 2 -> identical outputs; S1S0 holds at 2'b10 during the gap.
- Resync: send 2 slots (1,1), then sync=1 with din_valid=1, din=0, then 1,1,0 -> outputs y0=0, y1=1, y2=1, y3=0. No frame_valid occurs before this frame.
- Asynchronous reset mid-frame: after 3 slots, pulse rst_n low between clock edges -> outputs clear immediately, S1S0=0, and the following 4 slots form a new frame.
- DEMUX_FRAME_CNT_EN: send 257 back-to-back frames -> frame_cnt=1 and frame_valid pulses every 4th cycle.

Source files
------------

// File: rtl/demux_1x4_tdm.sv
// Registered 1:4 time-division demultiplexer: collects slots 0..3 from one lane and publishes whole frames.
// Optional macro DEMUX_FRAME_CNT_EN adds an 8-bit completed-frame counter output (frame_cnt).
module demux_1x4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             S1,
  output logic             S0,
`ifdef DEMUX_FRAME_CNT_EN
  output logic [7:0]       frame_cnt,
`endif
  output logic             frame_valid
);

  logic [1:0] slot_reg;
  logic [1:0] slot_next;
  logic [1:0] eff_slot;
  logic       frame_done;
  logic       frame_valid_reg;

  // sync overrides the pointer for this cycle only; the new pointer is derived from it below.
  always_comb begin
    eff_slot   = sync ? 2'd0 : slot_reg;
    frame_done = din_valid && (eff_slot == 2'd3);
    slot_next  = slot_reg;
    if (din_valid) begin
      slot_next = eff_slot + 2'd1;
    end else if (sync) begin
      slot_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg        <= 2'd0;
      frame_valid_reg <= 1'b0;
    end else begin
      slot_reg        <= slot_next;
      frame_valid_reg <= frame_done;
    end
  end

  genvar gi;

  // Shadow registers hold slots 0..2 until slot 3 arrives.
  for (gi = 0; gi < 3; gi++) begin : g_sh
    logic [WIDTH-1:0] sh_reg;
    logic             wr_en;

    assign wr_en = din_valid && (eff_slot == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_reg <= '0;
      end else if (wr_en) begin
        sh_reg <= din;
      end
    end
  end

  // Slot 3 bypasses the shadow stage so all four outputs update on the same edge.
  for (gi = 0; gi < 4; gi++) begin : g_out
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] y_next;

    if (gi < 3) begin : g_src
      assign y_next = g_sh[gi].sh_reg;
    end else begin : g_src
      assign y_next = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_reg <= '0;
      end else if (frame_done) begin
        y_reg <= y_next;
      end
    end
  end

  assign y0          = g_out[0].y_reg;
  assign y1          = g_out[1].y_reg;
  assign y2          = g_out[2].y_reg;
  assign y3          = g_out[3].y_reg;
  assign S1          = slot_reg[1];
  assign S0          = slot_reg[0];
  assign frame_valid = frame_valid_reg;

`ifdef DEMUX_FRAME_CNT_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= 8'd0;
    end else if (frame_done) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule
